// File: rtl/axil_master_q_if.sv
// AXI4-Lite bus bundle between axil_master_q and its slave.
// Signal names follow the AXI channel naming.
interface axil_master_q_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SW = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [SW-1:0]         WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_master_q.sv
// AXI4-Lite master fed by a command FIFO, one transaction in flight.
// Optional watchdog: define AXIL_MASTER_TIMEOUT_EN.
module axil_master_q #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    output logic                    rsp_wr,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,
    axil_master_q_if.master         axi
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = $clog2(CMD_DEPTH);

    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || CMD_DEPTH < 2 ||
        (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
        $error("axil_master_q: unsupported parameters");
    end

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [SW-1:0]         strb;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RSP} state_t;

    state_t      state;
    cmd_t        fifo_mem [CMD_DEPTH];
    cmd_t        head;
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic        tmo_hit;

    // Extra pointer bit distinguishes full from empty.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr[PW-1:0]];
    assign busy      = !empty || (state != IDLE);
    assign aw_hs     = axi.AWVALID && axi.AWREADY;
    assign w_hs      = axi.WVALID && axi.WREADY;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= {cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_ptr <= '0;
        else if (push) wr_ptr <= wr_ptr + 1'b1;
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state != IDLE) && (state != RSP) &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == IDLE) tmo_cnt <= '0;
            else if (state != RSP) tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit) rsp_timeout <= 1'b1;
            else if (state == RSP) rsp_timeout <= 1'b0;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi.AWADDR  <= '0;
            axi.AWVALID <= 1'b0;
            axi.WDATA   <= '0;
            axi.WSTRB   <= '0;
            axi.WVALID  <= 1'b0;
            axi.BREADY  <= 1'b0;
            axi.ARADDR  <= '0;
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_wr      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
        end else if (tmo_hit) begin
            // Abandon the bus; the slave must be reset by the system.
            axi.AWVALID <= 1'b0;
            axi.WVALID  <= 1'b0;
            axi.BREADY  <= 1'b0;
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b0;
            rsp_resp    <= 2'b10;
            rsp_valid   <= 1'b1;
            state       <= RSP;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: if (!empty) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    rsp_wr    <= head.wr;
                    rsp_rdata <= '0;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    if (head.wr) begin
                        axi.AWADDR  <= head.addr;
                        axi.WDATA   <= head.data;
                        axi.WSTRB   <= head.strb;
                        axi.AWVALID <= 1'b1;
                        axi.WVALID  <= 1'b1;
                        state       <= WR;
                    end else begin
                        axi.ARADDR  <= head.addr;
                        axi.ARVALID <= 1'b1;
                        state       <= RD_A;
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        axi.AWVALID <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        axi.WVALID <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        axi.BREADY <= 1'b1;
                        state      <= WR_B;
                    end
                end
                WR_B: if (axi.BVALID) begin
                    axi.BREADY <= 1'b0;
                    rsp_resp   <= axi.BRESP;
                    rsp_valid  <= 1'b1;
                    state      <= RSP;
                end
                RD_A: if (axi.ARREADY) begin
                    axi.ARVALID <= 1'b0;
                    axi.RREADY  <= 1'b1;
                    state       <= RD_D;
                end
                RD_D: if (axi.RVALID) begin
                    axi.RREADY <= 1'b0;
                    rsp_rdata  <= axi.RDATA;
                    rsp_resp   <= axi.RRESP;
                    rsp_valid  <= 1'b1;
                    state      <= RSP;
                end
                RSP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
